// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - ALU result producer / register-file consumer bus
interface alu_writeback_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [2:0] in_flags;
  logic [2:0] in_dest;
  logic       in_flag_we;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_dest;

  // Driver of results and consumer of the head entry (ALU + register file side)
  modport master (
    output in_valid, in_result, in_flags, in_dest, in_flag_we, out_ready,
    input  in_ready, out_valid, out_result, out_dest
  );

  // The writeback buffer itself
  modport slave (
    input  in_valid, in_result, in_flags, in_dest, in_flag_we, out_ready,
    output in_ready, out_valid, out_result, out_dest
  );
endinterface

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback buffer with architectural status flags
module alu_writeback #(
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  alu_writeback_if.slave  bus,
  output logic [2:0]      status_flags,
  output logic            full,
  output logic            empty
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    result_mem [DEPTH];
  logic [2:0]    dest_mem   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    hold_result;
  logic [2:0]    hold_dest;
  logic          push;
  logic          pop;

  // Pointers walk 0..DEPTH-1 and wrap back to slot 0
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_SLOT) ? '0 : ptr + PW'(1);
  endfunction

  assign full          = (count == FULL_COUNT);
  assign empty         = (count == '0);
  assign bus.in_ready  = !full && !reset;
  assign bus.out_valid = !empty && !reset;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // When the buffer drains, keep presenting the last entry that left it
  assign bus.out_result = empty ? hold_result : result_mem[rd_ptr];
  assign bus.out_dest   = empty ? hold_dest   : dest_mem[rd_ptr];

  // Payload storage; written only at accepting edges so idle bus values are never sampled
  always_ff @(posedge clock) begin
    if (push) begin
      result_mem[wr_ptr] <= bus.in_result;
      dest_mem[wr_ptr]   <= bus.in_dest;
    end
  end

  // Occupancy, pointers, held head value and architectural flags
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      hold_result  <= '0;
      hold_dest    <= '0;
      status_flags <= 3'b000;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
        if (bus.in_flag_we) begin
          status_flags <= bus.in_flags;
        end
      end
      if (pop) begin
        rd_ptr      <= next_ptr(rd_ptr);
        hold_result <= result_mem[rd_ptr];
        hold_dest   <= dest_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - scoreboard bench for alu_writeback
module tb_alu_writeback;

  localparam int DEPTH = 2;

  logic       clock;
  logic       reset;
  logic [2:0] status_flags;
  logic       full;
  logic       empty;

  alu_writeback_if bus ();

  alu_writeback #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .status_flags (status_flags),
    .full         (full),
    .empty        (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          started  = 0;
  int          model_count = 0;
  logic [2:0]  model_flags = 3'b000;
  logic [10:0] model_last  = '0;
  logic [10:0] exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy and flags advance at the clock edge from the driven inputs
  always @(posedge clock) begin
    bit acc;
    bit pp;
    if (reset) begin
      exp_q.delete();
      model_count = 0;
      model_flags = 3'b000;
      model_last  = '0;
      started     = 1;
    end else if (started) begin
      acc = bus.in_valid && (model_count < DEPTH);
      pp  = bus.out_ready && (model_count > 0);
      if (acc) begin
        exp_q.push_back({bus.in_result, bus.in_dest});
        if (bus.in_flag_we) model_flags = bus.in_flags;
      end
      model_count = model_count + int'(acc) - int'(pp);
    end
  end

  // Monitor: compare everything the DUT presents mid-cycle and retire consumed entries
  always @(negedge clock) begin
    if (started) begin
      chk("in_ready", bus.in_ready, int'(model_count < DEPTH && !reset));
      chk("out_valid", bus.out_valid, int'(model_count > 0 && !reset));
      chk("full", full, int'(model_count == DEPTH));
      chk("empty", empty, int'(model_count == 0));
      chk("status_flags", status_flags, model_flags);
      if (!reset) begin
        if (model_count > 0 && exp_q.size() > 0) begin
          chk("out_result", bus.out_result, exp_q[0][10:3]);
          chk("out_dest", bus.out_dest, exp_q[0][2:0]);
          if (bus.out_ready) model_last = exp_q.pop_front();
        end else begin
          chk("held_result", bus.out_result, model_last[10:3]);
          chk("held_dest", bus.out_dest, model_last[2:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_in(input bit v, input logic [7:0] r, input logic [2:0] f,
                        input logic [2:0] d, input bit we);
    bus.in_valid   = v;
    bus.in_result  = r;
    bus.in_flags   = f;
    bus.in_dest    = d;
    bus.in_flag_we = we;
  endtask

  task automatic idle_in();
    set_in(1'b0, 8'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
  endtask

  task automatic push_wait(input logic [7:0] r, input logic [2:0] f,
                           input logic [2:0] d, input bit we);
    bit ok;
    ok = 0;
    set_in(1'b1, r, f, d, we);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      ok = bus.in_ready;
      @(posedge clock);
      #1;
      if (ok) break;
    end
    chk("push_accept_timeout", ok, 1);
    idle_in();
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    set_in(1'b0, '0, '0, '0, 1'b0);
    step(2);
    reset = 1'b0;
    step(1);

    // single result
    push_wait(8'h2A, 3'b000, 3'd3, 1'b1);
    step(1);
    bus.out_ready = 1'b1;
    step(2);
    bus.out_ready = 1'b0;

    // fill, stall a third producer, pop once, then third is accepted
    push_wait(8'h01, 3'b010, 3'd1, 1'b1);
    push_wait(8'h02, 3'b011, 3'd2, 1'b0);
    set_in(1'b1, 8'h03, 3'b101, 3'd4, 1'b1);
    step(3);
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    push_wait(8'h03, 3'b101, 3'd4, 1'b1);
    bus.out_ready = 1'b1;
    step(3);

    // concurrent push and pop with one entry resident
    bus.out_ready = 1'b0;
    push_wait(8'h10, 3'b000, 3'd5, 1'b0);
    bus.out_ready = 1'b1;
    push_wait(8'h20, 3'b111, 3'd6, 1'b0);
    bus.out_ready = 1'b0;
    step(1);
    bus.out_ready = 1'b1;
    step(2);

    // flag ordering: second result does not write flags
    bus.out_ready = 1'b0;
    push_wait(8'h00, 3'b001, 3'd0, 1'b1);
    push_wait(8'hFF, 3'b110, 3'd7, 1'b0);
    step(1);
    bus.out_ready = 1'b1;
    step(3);

    // wrap-around: back-to-back push/pop
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 8'(i), 3'(i), 3'(i), 1'b1);
      step(1);
    end
    idle_in();
    step(3);

    // reset with a full buffer
    bus.out_ready = 1'b0;
    push_wait(8'hA1, 3'b100, 3'd1, 1'b1);
    push_wait(8'hA2, 3'b100, 3'd2, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    push_wait(8'h5C, 3'b010, 3'd6, 1'b1);
    step(1);
    bus.out_ready = 1'b1;
    step(2);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6)
        set_in(1'b1, 8'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
      else
        idle_in();
      bus.out_ready = ($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 49) == 0);
      step(1);
    end
    reset = 1'b0;
    idle_in();
    bus.out_ready = 1'b1;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of result-buffer entries; only DEPTH=2 is required.
REQ-002 clock  input  1  system clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 in_valid  input  1  ALU result/flags bus holds a result to capture.
REQ-005 in_ready  output  1  block can accept a result this cycle.
REQ-006 in_result  input  8  ALU result bus.
REQ-007 in_flags  input  3  ALU flag bus {carry, negative, zero}, MSB to LSB.
REQ-008 in_dest  input  3  destination register index for in_result.
REQ-009 in_flag_we  input  1  1 = this result also updates status_flags.
REQ-010 out_valid  output  1  head entry is available to the register file.
REQ-011 out_ready  input  1  register file consumes the head entry this cycle.
REQ-012 out_result  output  8  head entry result.
REQ-013 out_dest  output  3  head entry destination index.
REQ-014 status_flags  output  3  architectural {carry, negative, zero} register.
REQ-015 full  output  1  buffer holds DEPTH entries.
REQ-016 empty  output  1  buffer holds 0 entries.

Function
REQ-017 Accept: the block SHALL push {in_result, in_dest} when in_valid=1 and in_ready=1 at a rising edge.
REQ-018 Consume: the block SHALL pop the head entry when out_valid=1 and out_ready=1 at a rising edge.
REQ-019 in_ready SHALL equal !full && !reset, combinationally.
REQ-020 out_valid SHALL equal !empty, registered state only; there is no same-cycle bypass.
REQ-021 Latency: a result accepted at edge N SHALL appear on out_* after edge N if the buffer was empty.
REQ-022 Ordering: results SHALL leave in acceptance order, with no loss and no duplication.
REQ-023 Occupancy SHALL be a 0..2 count with 1-bit read and write pointers that wrap from 1 to 0.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged; the pushed data goes to the write slot and the head advances.
REQ-025 When full with in_valid=1 and a pop in the same edge, the block SHALL NOT accept, because in_ready was 0; the result SHALL be accepted on a following edge once in_ready=1.
REQ-026 When empty with out_ready=1, nothing SHALL change.
REQ-027 in_valid while in_ready=0 SHALL stall the producer; no data is dropped or overwritten.
REQ-028 out_result and out_dest SHALL show the head slot while out_valid=1, and SHALL hold their last value when empty (0 after reset).
REQ-029 status_flags SHALL load in_flags at the accepting edge when in_flag_we=1, independent of pop timing.
REQ-030 Otherwise status_flags SHALL hold.
REQ-031 in_* buses may be high-impedance when not valid; the block SHALL sample them only at accepting edges.
REQ-032 full SHALL be 1 exactly when count=2, and empty SHALL be 1 exactly when count=0.

Reset
REQ-033 When reset=1 at an edge, the block SHALL set count to 0 and both pointers to 0.
REQ-034 The same reset edge SHALL set status_flags to 3'b000 and out_result/out_dest to 0.
REQ-035 Reset SHALL override a simultaneous push or pop.
REQ-036 Entries in flight at reset SHALL be discarded.
REQ-037 During reset, in_ready and out_valid SHALL be 0.
REQ-038 The cycle after reset deasserts, in_ready SHALL be 1 and empty SHALL be 1.

Verification
REQ-039 Single result: push result 8'h2A, dest 3, flags 3'b000, flag_we=1 with out_ready=0 -> next cycle out_valid=1, out_result=8'h2A, out_dest=3, status_flags=3'b000, empty=0, full=0.
REQ-040 Fill and stall: push 8'h01 then 8'h02 with out_ready=0 -> full=1, in_ready=0; a third in_valid with 8'h03 is held, not accepted; a pop then yields 8'h01 first, in_ready returns to 1, and 8'h03 is accepted on the following edge.
REQ-041 Concurrent push/pop: count=1 holding 8'h10; push 8'h20 with out_ready=1 -> after the edge count=1, out_result=8'h20.
REQ-042 Flag ordering: push 8'h00 (flags 3'b001, we=1) then 8'hFF (flags 3'b110, we=0) -> status_flags=3'b001 after both edges, regardless of pops.
REQ-043 Wrap-around: 10 back-to-back push/pop pairs of 0x00..0x09 with out_ready=1 -> outputs emerge 0x00..0x09 in order, never full.
REQ-044 Mid-operation reset: full buffer with flags 3'b100 and reset=1 for one edge -> count=0, status_flags=3'b000, out_valid=0; the next push after release appears alone.
